// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: opcodes, flag bit positions and FSM states shared by the ALU sequencer
package alu_sequencer_pkg;
  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_SUBC = 8'h0A;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MUL  = 8'h0E;
  localparam logic [7:0] OP_LSH  = 8'h84;
  localparam logic [7:0] OP_ASHU = 8'h86;
  localparam int F_C = 0;
  localparam int F_Z = 1;
  localparam int F_F = 2;
  localparam int F_L = 3;
  localparam int F_N = 4;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;
  function automatic logic is_legal(input logic [7:0] op);
    return op inside {OP_AND, OP_OR, OP_XOR, OP_ADD, OP_ADDU, OP_ADDC,
                      OP_SUB, OP_SUBC, OP_CMP, OP_MUL, OP_LSH, OP_ASHU};
  endfunction
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command, ALU, status and debug-read signals of the ALU sequencer
interface alu_sequencer_if #(parameter int DATA_W = 16, parameter int REG_AW = 4);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_opcode;
  logic [REG_AW-1:0] cmd_rdest;
  logic [REG_AW-1:0] cmd_rsrc;
  logic [DATA_W-1:0] cmd_imm;
  logic              cmd_use_imm;
  logic [DATA_W-1:0] alu_r1;
  logic [DATA_W-1:0] alu_r2;
  logic [7:0]        alu_opcode;
  logic [DATA_W-1:0] alu_rout;
  logic              done;
  logic              illegal;
  logic [DATA_W-1:0] result;
  logic [4:0]        flags;
  logic [REG_AW-1:0] dbg_raddr;
  logic [DATA_W-1:0] dbg_rdata;
  modport master (
    output cmd_valid, cmd_opcode, cmd_rdest, cmd_rsrc, cmd_imm, cmd_use_imm, alu_rout, dbg_raddr,
    input  cmd_ready, alu_r1, alu_r2, alu_opcode, done, illegal, result, flags, dbg_rdata
  );
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_rdest, cmd_rsrc, cmd_imm, cmd_use_imm, alu_rout, dbg_raddr,
    output cmd_ready, alu_r1, alu_r2, alu_opcode, done, illegal, result, flags, dbg_rdata
  );
endinterface

// File: rtl/alu_sequencer_regfile.sv
// alu_sequencer_regfile: register file with two operand read ports, a debug read port and one write port
module alu_sequencer_regfile #(parameter int DATA_W = 16, parameter int REG_AW = 4) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic [REG_AW-1:0] rdbg,
  output logic [DATA_W-1:0] rda,
  output logic [DATA_W-1:0] rdb,
  output logic [DATA_W-1:0] rddbg
);
  logic [DATA_W-1:0] mem_q [2**REG_AW];
  assign rda   = mem_q[ra];
  assign rdb   = mem_q[rb];
  assign rddbg = mem_q[rdbg];
  always_ff @(posedge clock) begin
    if (reset) mem_q <= '{default: '0};
    else if (we) mem_q[waddr] <= wdata;
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: three-cycle IDLE/EXEC/WB controller driving an external ALU with writeback and status flags
module alu_sequencer
  import alu_sequencer_pkg::*;
#(parameter int DATA_W = 16, parameter int REG_AW = 4) (
  input logic            clock,
  input logic            reset,
  alu_sequencer_if.slave bus
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, result_q, result_d;
  logic [7:0]        op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [4:0]        nfl_q, nfl_d, flags_q, flags_d, nfl;
  logic              done_q, done_d, ill_q, ill_d;
  logic [DATA_W-1:0] rda, rdb, fin;
  logic [DATA_W:0]   sum, bsub, diff;
  logic              cin, accept, legal, we, is_add, is_sub, is_cmp, ovf_add, ovf_sub;
  assign we = state_q == S_WB && is_legal(op_q) && op_q != OP_CMP;
  alu_sequencer_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
    .clock(clock), .reset(reset), .we(we), .waddr(rd_q), .wdata(res_q),
    .ra(bus.cmd_rdest), .rb(bus.cmd_rsrc), .rdbg(bus.dbg_raddr),
    .rda(rda), .rdb(rdb), .rddbg(bus.dbg_rdata)
  );
  always_comb begin
    cin      = flags_q[F_C];
    legal    = is_legal(op_q);
    is_add   = op_q inside {OP_ADD, OP_ADDC};
    is_sub   = op_q inside {OP_SUB, OP_SUBC};
    is_cmp   = op_q == OP_CMP;
    sum      = {1'b0, a_q} + {1'b0, b_q} + {{DATA_W{1'b0}}, op_q == OP_ADDC && cin};
    bsub     = {1'b0, b_q} + {{DATA_W{1'b0}}, op_q == OP_SUBC && cin};
    diff     = {1'b0, a_q} - bsub;
    ovf_add  = a_q[DATA_W-1] == b_q[DATA_W-1] && sum[DATA_W-1] != a_q[DATA_W-1];
    ovf_sub  = a_q[DATA_W-1] != b_q[DATA_W-1] && diff[DATA_W-1] != a_q[DATA_W-1];
    fin      = op_q == OP_ADDC ? bus.alu_rout + DATA_W'(cin) :
               op_q == OP_SUBC ? bus.alu_rout - DATA_W'(cin) : bus.alu_rout;
    nfl[F_C] = (is_add || op_q == OP_ADDU) ? sum[DATA_W] : is_sub ? ({1'b0, a_q} < bsub) : flags_q[F_C];
    nfl[F_F] = is_add ? ovf_add : is_sub ? ovf_sub : flags_q[F_F];
    nfl[F_Z] = is_cmp ? a_q == b_q : flags_q[F_Z];
    nfl[F_L] = is_cmp ? a_q < b_q : flags_q[F_L];
    nfl[F_N] = is_cmp ? $signed(a_q) < $signed(b_q) : flags_q[F_N];
    accept   = state_q == S_IDLE && bus.cmd_valid;
    state_d  = accept ? S_EXEC : state_q == S_EXEC ? S_WB : S_IDLE;
    a_d      = accept ? rda : a_q;
    b_d      = accept ? (bus.cmd_use_imm ? bus.cmd_imm : rdb) : b_q;
    op_d     = accept ? bus.cmd_opcode : op_q;
    rd_d     = accept ? bus.cmd_rdest : rd_q;
    res_d    = state_q == S_EXEC ? (legal ? fin : result_q) : res_q;
    nfl_d    = state_q == S_EXEC ? nfl : nfl_q;
    result_d = state_q == S_WB ? res_q : result_q;
    flags_d  = state_q == S_WB ? nfl_q : flags_q;
    done_d   = state_q == S_WB;
    ill_d    = state_q == S_WB && !legal;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      res_q    <= '0;
      nfl_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      res_q    <= res_d;
      nfl_q    <= nfl_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      ill_q    <= ill_d;
    end
  end
  assign bus.cmd_ready  = state_q == S_IDLE;
  assign bus.alu_r1     = a_q;
  assign bus.alu_r2     = b_q;
  assign bus.alu_opcode = op_q;
  assign bus.done       = done_q;
  assign bus.illegal    = ill_q;
  assign bus.result     = result_q;
  assign bus.flags      = flags_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed table-driven check of the ALU sequencer against a behavioural ALU
module tb_alu_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  alu_sequencer_if #(.DATA_W(16), .REG_AW(4)) bus ();
  alu_sequencer #(.DATA_W(16), .REG_AW(4)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  logic [15:0] nb;
  assign nb = -bus.alu_r2;
  always_comb begin
    case (bus.alu_opcode)
      8'h01: bus.alu_rout = bus.alu_r1 & bus.alu_r2;
      8'h02: bus.alu_rout = bus.alu_r1 | bus.alu_r2;
      8'h03: bus.alu_rout = bus.alu_r1 ^ bus.alu_r2;
      8'h05, 8'h06, 8'h07: bus.alu_rout = bus.alu_r1 + bus.alu_r2;
      8'h09, 8'h0A, 8'h0B: bus.alu_rout = bus.alu_r1 - bus.alu_r2;
      8'h0E: bus.alu_rout = bus.alu_r1 * bus.alu_r2;
      8'h84: bus.alu_rout = bus.alu_r2[15] ? bus.alu_r1 >> nb[3:0] : bus.alu_r1 << bus.alu_r2[3:0];
      8'h86: bus.alu_rout = bus.alu_r2[15] ? 16'($signed(bus.alu_r1) >>> nb[3:0]) : bus.alu_r1 << bus.alu_r2[3:0];
      default: bus.alu_rout = 16'hDEAD;
    endcase
  end
  typedef struct {
    logic [7:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] imm;
    logic        ui;
    logic [15:0] res;
    logic [4:0]  fl;
    logic        ill;
    logic [15:0] reg_v;
  } vec_t;
  vec_t v[19];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_cmd(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                         input logic [15:0] imm, input logic ui);
    int n;
    chk("ready before issue", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_rdest = rd;
    bus.cmd_rsrc = rs;
    bus.cmd_imm = imm;
    bus.cmd_use_imm = ui;
    @(posedge clock);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    n = 1;
    while (!bus.done && n < 8) begin
      @(negedge clock);
      n++;
    end
    chk("done latency", n, 3);
  endtask
  initial begin
    v[0]  = '{8'h05, 4'd1, 4'd0, 16'h0005, 1'b1, 16'h0005, 5'b00000, 1'b0, 16'h0005};
    v[1]  = '{8'h05, 4'd1, 4'd0, 16'hFFFA, 1'b1, 16'hFFFF, 5'b00000, 1'b0, 16'hFFFF};
    v[2]  = '{8'h06, 4'd1, 4'd0, 16'h0001, 1'b1, 16'h0000, 5'b00001, 1'b0, 16'h0000};
    v[3]  = '{8'h07, 4'd2, 4'd0, 16'h0000, 1'b1, 16'h0001, 5'b00000, 1'b0, 16'h0001};
    v[4]  = '{8'h05, 4'd3, 4'd0, 16'h7FFF, 1'b1, 16'h7FFF, 5'b00000, 1'b0, 16'h7FFF};
    v[5]  = '{8'h05, 4'd3, 4'd0, 16'h0001, 1'b1, 16'h8000, 5'b00100, 1'b0, 16'h8000};
    v[6]  = '{8'h09, 4'd3, 4'd0, 16'h0001, 1'b1, 16'h7FFF, 5'b00100, 1'b0, 16'h7FFF};
    v[7]  = '{8'h05, 4'd1, 4'd0, 16'h0003, 1'b1, 16'h0003, 5'b00000, 1'b0, 16'h0003};
    v[8]  = '{8'h0B, 4'd1, 4'd0, 16'h0007, 1'b1, 16'hFFFC, 5'b11000, 1'b0, 16'h0003};
    v[9]  = '{8'h55, 4'd1, 4'd0, 16'h0009, 1'b1, 16'hFFFC, 5'b11000, 1'b1, 16'h0003};
    v[10] = '{8'h0B, 4'd1, 4'd0, 16'h0003, 1'b1, 16'h0000, 5'b00010, 1'b0, 16'h0003};
    v[11] = '{8'h03, 4'd1, 4'd3, 16'h0000, 1'b0, 16'h7FFC, 5'b00010, 1'b0, 16'h7FFC};
    v[12] = '{8'h09, 4'd5, 4'd1, 16'h0000, 1'b0, 16'h8004, 5'b00011, 1'b0, 16'h8004};
    v[13] = '{8'h0A, 4'd5, 4'd0, 16'h0000, 1'b1, 16'h8003, 5'b00010, 1'b0, 16'h8003};
    v[14] = '{8'h0E, 4'd1, 4'd1, 16'h0000, 1'b0, 16'h0010, 5'b00010, 1'b0, 16'h0010};
    v[15] = '{8'h09, 4'd6, 4'd0, 16'h0001, 1'b1, 16'hFFFF, 5'b00011, 1'b0, 16'hFFFF};
    v[16] = '{8'h07, 4'd6, 4'd0, 16'h0001, 1'b1, 16'h0001, 5'b00011, 1'b0, 16'h0001};
    v[17] = '{8'h84, 4'd6, 4'd0, 16'h0004, 1'b1, 16'h0010, 5'b00011, 1'b0, 16'h0010};
    v[18] = '{8'h86, 4'd5, 4'd0, 16'hFFFF, 1'b1, 16'hC001, 5'b00011, 1'b0, 16'hC001};
    bus.cmd_valid = 1'b0;
    bus.cmd_opcode = '0;
    bus.cmd_rdest = '0;
    bus.cmd_rsrc = '0;
    bus.cmd_imm = '0;
    bus.cmd_use_imm = 1'b0;
    bus.dbg_raddr = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset ready", bus.cmd_ready, 1);
    chk("reset done", bus.done, 0);
    chk("reset illegal", bus.illegal, 0);
    chk("reset result", bus.result, 0);
    chk("reset flags", bus.flags, 0);
    chk("reset alu_r1", bus.alu_r1, 0);
    chk("reset alu_opcode", bus.alu_opcode, 0);
    chk("reset R0", bus.dbg_rdata, 0);
    reset = 1'b0;
    for (int i = 0; i < 19; i++) begin
      run_cmd(v[i].op, v[i].rd, v[i].rs, v[i].imm, v[i].ui);
      bus.dbg_raddr = v[i].rd;
      #1;
      chk($sformatf("v%0d result", i), bus.result, v[i].res);
      chk($sformatf("v%0d flags", i), bus.flags, v[i].fl);
      chk($sformatf("v%0d illegal", i), bus.illegal, v[i].ill);
      chk($sformatf("v%0d reg", i), bus.dbg_rdata, v[i].reg_v);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_opcode = 8'h01;
    bus.cmd_rdest = 4'd8;
    bus.cmd_imm = 16'h0000;
    bus.cmd_use_imm = 1'b1;
    bus.dbg_raddr = 4'd8;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("stream%0d ready", i), bus.cmd_ready, i % 3 == 0);
      chk($sformatf("stream%0d done", i), bus.done, i % 3 == 0);
      chk($sformatf("stream%0d illegal", i), bus.illegal, 0);
      @(posedge clock);
      #1;
    end
    chk("stream final done", bus.done, 1);
    chk("stream R8", bus.dbg_rdata, 0);
    bus.cmd_valid = 1'b0;
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_opcode = 8'h05;
    bus.cmd_rdest = 4'd4;
    bus.cmd_imm = 16'h1234;
    bus.dbg_raddr = 4'd4;
    @(posedge clock);
    #1;
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    chk("abort exec opcode", bus.alu_opcode, 8'h05);
    chk("abort exec ready", bus.cmd_ready, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("abort done", bus.done, 0);
    chk("abort ready", bus.cmd_ready, 1);
    chk("abort R4", bus.dbg_rdata, 0);
    chk("abort result", bus.result, 0);
    chk("abort flags", bus.flags, 0);
    repeat (2) begin
      @(posedge clock);
      #1;
      chk("abort no late done", bus.done, 0);
      chk("abort R4 later", bus.dbg_rdata, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
